// File: rtl/adder_mc_seq.sv
// Multicycle wrapper around a combinational ripple-carry adder: registers operands,
// waits SETTLE_CYCLES edges for the carry chain, then hands the sum downstream.
module adder_mc_seq #(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_A,
    input  logic [7:0] in_B,
    output logic [7:0] adder_A,
    output logic [7:0] adder_B,
    input  logic [8:0] adder_S,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] out_S,
    output logic       out_carry,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [8:0] s_q, s_d;
    logic       ov_q, ov_d;
    logic [7:0] cnt_ops_q, cnt_ops_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            s_q       <= 9'd0;
            ov_q      <= 1'b0;
            cnt_ops_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            ov_q      <= ov_d;
            cnt_ops_q <= cnt_ops_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        ov_d      = ov_q;
        cnt_ops_d = cnt_ops_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_A;
                    b_d     = in_B;
                    cnt_d   = CNT_INIT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // Sample only once the carry chain has had its full window.
                if (cnt_q == 4'd0) begin
                    s_d     = adder_S;
                    ov_d    = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    ov_d      = 1'b0;
                    cnt_ops_d = cnt_ops_q + 8'd1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = reset_n & (state_q == IDLE);
    assign adder_A   = a_q;
    assign adder_B   = b_q;
    assign out_valid = ov_q;
    assign out_S     = s_q;
    assign out_carry = s_q[8];
    assign op_count  = cnt_ops_q;

endmodule
